// File: rtl/conv_engine_seq.sv
// Sequential Float8 2-D valid convolution: one multiply-accumulate per cycle, bias, raster-order
// output over valid/ready. Defining CONV_ENGINE_RELU_EN clamps negative results to zero.
module conv_engine_seq #(
  parameter int unsigned IN_W = 12,
  parameter int unsigned IN_H = 12,
  parameter int unsigned K    = 5,
  parameter int unsigned CH   = 1,
  localparam int unsigned OUT_W = IN_W - K + 1,
  localparam int unsigned OUT_H = IN_H - K + 1,
  localparam int unsigned RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int unsigned CLW   = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [CH*IN_H*IN_W*8-1:0]  tensor_in,
  input  logic [CH*K*K*8-1:0]        filter_in,
  input  logic [7:0]                 bias_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  output logic [RW-1:0]              out_row,
  output logic [CLW-1:0]             out_col,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
);

  localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [KW-1:0]  KLast   = KW'(K - 1);
  localparam logic [CW-1:0]  ChLast  = CW'(CH - 1);
  localparam logic [RW-1:0]  RowLast = RW'(OUT_H - 1);
  localparam logic [CLW-1:0] ColLast = CLW'(OUT_W - 1);

  typedef enum logic [2:0] {StIdle, StMac, StBias, StEmit, StDone} state_e;

  state_e         state_q, state_d;
  logic [7:0]     acc_q, acc_d;
  logic [7:0]     out_data_q, out_data_d;
  logic [KW-1:0]  kc_q, kc_d, kr_q, kr_d;
  logic [CW-1:0]  c_q, c_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CLW-1:0] col_q, col_d;
  logic           ovf_q, ovf_d;

  // Magnitude as an integer in units of 2^-9 (the LSB of the smallest normal value).
  function automatic logic [17:0] f8_mag(input logic [7:0] a);
    if (a[6:3] == 4'd0) return 18'd0;
    return 18'({1'b1, a[2:0]}) << (a[6:3] - 4'd1);
  endfunction

  // Returns {overflow, result}; exact product truncated toward zero.
  function automatic logic [8:0] f8_mul(input logic [7:0] a, input logic [7:0] b);
    logic              s;
    logic [7:0]        p;
    logic [7:0]        pn;
    logic signed [6:0] e;
    s = a[7] ^ b[7];
    p = 8'({1'b1, a[2:0]}) * 8'({1'b1, b[2:0]});
    e = 7'(a[6:3]) + 7'(b[6:3]) - 7'd7;
    if (p[7]) begin
      pn = p;
      e  = e + 7'sd1;
    end else begin
      pn = p << 1;
    end
    if (a[6:3] == 4'd0 || b[6:3] == 4'd0) return 9'd0;
    // pn carries the full significand, so 240 here means exactly 1.875 (the 480 ceiling).
    if (e > 7'sd15 || (e == 7'sd15 && pn > 8'd240)) return {1'b1, s, 7'h7F};
    if (e < 7'sd1) return 9'd0;
    return {1'b0, s, e[3:0], pn[6:4]};
  endfunction

  // Returns {overflow, result}; exact sum truncated toward zero.
  function automatic logic [8:0] f8_add(input logic [7:0] a, input logic [7:0] b);
    logic signed [19:0] va, vb, sum;
    logic [18:0]        mag;
    int                 msb;
    va = 20'(f8_mag(a));
    vb = 20'(f8_mag(b));
    if (a[7]) va = -va;
    if (b[7]) vb = -vb;
    sum = va + vb;
    mag = sum[19] ? 19'(-sum) : sum[18:0];
    msb = 0;
    for (int i = 0; i < 19; i++) begin
      if (mag[i]) msb = i;
    end
    if (mag > 19'd245760) return {1'b1, sum[19], 7'h7F};
    if (mag < 19'd8) return 9'd0;
    return {1'b0, sum[19], 4'(msb - 2), 3'(mag >> (msb - 3))};
  endfunction

  int unsigned t_idx, f_idx;
  logic [7:0]  t_el, f_el, prod, add_b, add_res;
  logic        mul_ovf, add_ovf;

  always_comb begin
    t_idx = ((int'(c_q) * int'(IN_H) + int'(row_q) + int'(kr_q)) * int'(IN_W)
             + int'(col_q) + int'(kc_q));
    f_idx = (int'(c_q) * int'(K) + int'(kr_q)) * int'(K) + int'(kc_q);
  end

  assign t_el = tensor_in[t_idx*8 +: 8];
  assign f_el = filter_in[f_idx*8 +: 8];

  // One adder is shared between the MAC terms and the final bias addition.
  always_comb begin
    {mul_ovf, prod}    = f8_mul(t_el, f_el);
    add_b              = (state_q == StBias) ? bias_in : prod;
    {add_ovf, add_res} = f8_add(acc_q, add_b);
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    kc_d       = kc_q;
    kr_d       = kr_q;
    c_d        = c_q;
    row_d      = row_q;
    col_d      = col_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMac;
          acc_d   = '0;
          kc_d    = '0;
          kr_d    = '0;
          c_d     = '0;
          row_d   = '0;
          col_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StMac: begin
        acc_d = add_res;
        ovf_d = ovf_q | mul_ovf | add_ovf;
        if (kc_q == KLast) begin
          kc_d = '0;
          if (kr_q == KLast) begin
            kr_d = '0;
            if (c_q == ChLast) begin
              c_d     = '0;
              state_d = StBias;
            end else begin
              c_d = c_q + 1'b1;
            end
          end else begin
            kr_d = kr_q + 1'b1;
          end
        end else begin
          kc_d = kc_q + 1'b1;
        end
      end
      StBias: begin
        acc_d   = '0;
        ovf_d   = ovf_q | add_ovf;
        state_d = StEmit;
`ifdef CONV_ENGINE_RELU_EN
        out_data_d = (add_res[7] && add_res[6:0] != 7'd0) ? 8'h00 : add_res;
`else
        out_data_d = add_res;
`endif
      end
      StEmit: begin
        if (out_ready) begin
          state_d = StMac;
          if (col_q == ColLast) begin
            col_d = '0;
            if (row_q == RowLast) begin
              row_d   = '0;
              state_d = StDone;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      out_data_q <= '0;
      kc_q       <= '0;
      kr_q       <= '0;
      c_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      kc_q       <= kc_d;
      kr_q       <= kr_d;
      c_q        <= c_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = (state_q == StEmit);
  assign out_data  = out_data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_conv_engine_seq.sv
// Randomised bench for conv_engine_seq against a real-arithmetic Float8 model.
module tb_conv_engine_seq;

  localparam int IN_W  = 12;
  localparam int IN_H  = 12;
  localparam int K     = 5;
  localparam int CH    = 1;
  localparam int OUT_W = IN_W - K + 1;
  localparam int OUT_H = IN_H - K + 1;
  localparam int N     = K * K * CH;
  localparam int NPIX  = OUT_W * OUT_H;
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int CLW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int LIMIT = NPIX * (N + 40) + 200;

  logic                      clk;
  logic                      rst_n;
  logic                      start;
  logic [CH*IN_H*IN_W*8-1:0] tensor_in;
  logic [CH*K*K*8-1:0]       filter_in;
  logic [7:0]                bias_in;
  logic                      out_ready;
  logic                      out_valid;
  logic [7:0]                out_data;
  logic [RW-1:0]             out_row;
  logic [CLW-1:0]            out_col;
  logic                      busy;
  logic                      done;
  logic                      overflow;

  logic [7:0] t_arr [CH*IN_H*IN_W];
  logic [7:0] f_arr [CH*K*K];
  logic [7:0] b_val;
  logic [7:0] exp_q [$];
  bit         exp_ovf;
  int         checks;
  int         errors;

  conv_engine_seq #(.IN_W(IN_W), .IN_H(IN_H), .K(K), .CH(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tensor_in (tensor_in),
    .filter_in (filter_in),
    .bias_in   (bias_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic real dec(input logic [7:0] b);
    real v;
    int  e;
    e = int'(b[6:3]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(int'(b[2:0])) / 8.0;
    for (int i = 7; i < e; i++) v = v * 2.0;
    for (int i = e; i < 7; i++) v = v / 2.0;
    return b[7] ? -v : v;
  endfunction

  // Largest representable magnitude not above |v|, i.e. truncation toward zero.
  function automatic logic [7:0] enc(input real v);
    real        a;
    logic [7:0] best;
    logic [7:0] code;
    a    = (v < 0.0) ? -v : v;
    best = 8'h00;
    for (int i = 8; i < 128; i++) begin
      code = 8'(i);
      if (dec(code) <= a) best = code;
    end
    if (best == 8'h00) return 8'h00;
    return (v < 0.0) ? (best | 8'h80) : best;
  endfunction

  function automatic bit too_big(input real v);
    return (v > 480.0) || (v < -480.0);
  endfunction

  task automatic build_model;
    logic [7:0] acc;
    logic [7:0] pb;
    real        p;
    real        s;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int r = 0; r < OUT_H; r++) begin
      for (int x = 0; x < OUT_W; x++) begin
        acc = 8'h00;
        for (int c = 0; c < CH; c++) begin
          for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K; kc++) begin
              p = dec(t_arr[(c*IN_H + r + kr)*IN_W + x + kc]) * dec(f_arr[(c*K + kr)*K + kc]);
              if (too_big(p)) exp_ovf = 1'b1;
              pb = enc(p);
              s  = dec(acc) + dec(pb);
              if (too_big(s)) exp_ovf = 1'b1;
              acc = enc(s);
            end
          end
        end
        s = dec(acc) + dec(b_val);
        if (too_big(s)) exp_ovf = 1'b1;
        acc = enc(s);
`ifdef CONV_ENGINE_RELU_EN
        if (dec(acc) < 0.0) acc = 8'h00;
`endif
        exp_q.push_back(acc);
      end
    end
  endtask

  task automatic load_inputs;
    for (int i = 0; i < CH*IN_H*IN_W; i++) tensor_in[i*8 +: 8] = t_arr[i];
    for (int i = 0; i < CH*K*K; i++) filter_in[i*8 +: 8] = f_arr[i];
    bias_in = b_val;
  endtask

  task automatic set_const(input logic [7:0] tv, input logic [7:0] fv, input logic [7:0] bv);
    for (int i = 0; i < CH*IN_H*IN_W; i++) t_arr[i] = tv;
    for (int i = 0; i < CH*K*K; i++) f_arr[i] = fv;
    b_val = bv;
  endtask

  // ready_mode: 0 always ready, 1 random, 2 hold off 10 valid cycles at pixel (0,0).
  task automatic run_frame(input int ready_mode, input int start_pulse_cyc);
    int  idx;
    int  cyc;
    int  last_xfer;
    int  hold;
    bit  pv;
    bit  pready;
    build_model();
    load_inputs();
    start = 1'b1;
    out_ready = 1'b0;
    step();
    start = 1'b0;
    cyc = 1;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear_on_start: got %0b expected 0", overflow);
    end
    idx = 0;
    last_xfer = 0;
    hold = 0;
    pv = 1'b0;
    pready = 1'b0;
    while (idx < NPIX && cyc < LIMIT) begin
      start = (cyc == start_pulse_cyc);
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else out_ready = !(idx == 0 && hold < 10);
      if (pv && !pready && !out_valid) begin
        checks++;
        errors++;
        $display("FAIL valid_dropped: got 0 expected 1 at pixel %0d", idx);
      end
      if (out_valid) begin
        if (!pv) begin
          checks++;
          if (cyc != last_xfer + N + 2) begin
            errors++;
            $display("FAIL latency: pixel %0d got cycle %0d expected %0d", idx, cyc,
                     last_xfer + N + 2);
          end
        end
        checks++;
        if (out_data !== exp_q[idx] || out_row !== RW'(idx / OUT_W) ||
            out_col !== CLW'(idx % OUT_W)) begin
          errors++;
          $display("FAIL pixel: idx %0d got %0h (%0d,%0d) expected %0h (%0d,%0d)", idx,
                   out_data, out_row, out_col, exp_q[idx], idx / OUT_W, idx % OUT_W);
        end
        if (!out_ready) hold++;
        if (out_ready) begin
          last_xfer = cyc;
          idx++;
        end
      end
      pv = out_valid;
      pready = out_ready;
      step();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (idx < NPIX) begin
      errors++;
      $display("FAIL frame_timeout: got %0d pixels expected %0d", idx, NPIX);
    end else begin
      if (done !== 1'b1 || busy !== 1'b1 || overflow !== exp_ovf) begin
        errors++;
        $display("FAIL done_cycle: got done %0b busy %0b ovf %0b expected 1 1 %0b", done, busy,
                 overflow, exp_ovf);
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || overflow !== exp_ovf) begin
        errors++;
        $display("FAIL idle_after_done: got done %0b busy %0b ovf %0b expected 0 0 %0b", done,
                 busy, overflow, exp_ovf);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    set_const(8'h00, 8'h00, 8'h00);
    load_inputs();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({out_valid, out_data, out_row, out_col, busy, done, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid %0b data %0h row %0d col %0d busy %0b done %0b ovf %0b expected all 0",
               out_valid, out_data, out_row, out_col, busy, done, overflow);
    end
  endtask

  task automatic test_ones;
    set_const(8'h38, 8'h38, 8'h00);
    run_frame(0, -1);
  endtask

  task automatic test_saturate;
    set_const(8'h7F, 8'h7F, 8'h00);
    run_frame(1, -1);
    repeat (5) step();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %0b expected 1", overflow);
    end
    // The next frame's first cycle is checked for the cleared flag.
    set_const(8'h38, 8'h38, 8'h00);
    run_frame(0, -1);
  endtask

  task automatic test_negative;
    set_const(8'h38, 8'hB8, 8'h00);
    run_frame(0, -1);
  endtask

  task automatic test_backpressure;
    set_const(8'h38, 8'h30, 8'h40);
    run_frame(2, -1);
  endtask

  task automatic test_start_ignored;
    set_const(8'h3C, 8'h34, 8'hB0);
    run_frame(0, 5);
  endtask

  task automatic test_reset_mid;
    int xfers;
    int cyc;
    set_const(8'h38, 8'h38, 8'h00);
    load_inputs();
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    xfers = 0;
    cyc = 0;
    while (xfers < 3 && cyc < LIMIT) begin
      if (out_valid && out_ready) xfers++;
      step();
      cyc++;
    end
    repeat (5) step();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || out_col !== CLW'(3)) begin
      errors++;
      $display("FAIL mid_frame_pos: got busy %0b valid %0b col %0d expected 1 0 3", busy,
               out_valid, out_col);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({out_valid, out_data, out_row, out_col, busy, done, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got valid %0b data %0h row %0d col %0d busy %0b done %0b expected all 0",
               out_valid, out_data, out_row, out_col, busy, done);
    end
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid || busy) cyc++;
      step();
    end
    checks++;
    if (cyc != 0) begin
      errors++;
      $display("FAIL reset_quiet: got %0d active cycles expected 0", cyc);
    end
    run_frame(0, -1);
  endtask

  task automatic test_random;
    for (int i = 0; i < CH*IN_H*IN_W; i++) t_arr[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < CH*K*K; i++) f_arr[i] = 8'($urandom_range(0, 255));
    b_val = 8'($urandom_range(0, 255));
    run_frame(1, -1);
    // Mid-range exponents keep sums away from saturation so truncation dominates.
    for (int i = 0; i < CH*IN_H*IN_W; i++)
      t_arr[i] = {1'($urandom_range(0, 1)), 4'($urandom_range(5, 9)), 3'($urandom_range(0, 7))};
    for (int i = 0; i < CH*K*K; i++)
      f_arr[i] = {1'($urandom_range(0, 1)), 4'($urandom_range(5, 9)), 3'($urandom_range(0, 7))};
    b_val = {1'($urandom_range(0, 1)), 4'($urandom_range(4, 10)), 3'($urandom_range(0, 7))};
    run_frame(1, -1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tensor_in = '0;
    filter_in = '0;
    bias_in = '0;
    test_reset();
    test_ones();
    test_saturate();
    test_negative();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_engine_seq.md
# conv_engine_seq

Sequential, parametrised Float8 2-D valid convolution engine for the TPU datapath; successor to the fixed 12×12/5×5 combinational conv stage. It computes one multiply-accumulate per cycle over CH input channels, adds a bias, and streams each output pixel in raster order over a valid/ready handshake. It trades area for latency, so larger feature maps and multi-channel layers fit the device.

## Interface
- IN_W, 12, input tensor width (pixels)
- IN_H, 12, input tensor height
- K, 5, square kernel side; OUT_W = IN_W-K+1, OUT_H = IN_H-K+1
- CH, 1, input channel count summed into each output
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  begin a frame; sampled only in IDLE
- tensor_in  input  CH*IN_H*IN_W*8  element (c,r,x) at bits [((c*IN_H+r)*IN_W+x)*8 +: 8]; held stable while busy
- filter_in  input  CH*K*K*8  element (c,kr,kc) at [((c*K+kr)*K+kc)*8 +: 8]; stable while busy
- bias_in  input  8  Float8 bias; stable while busy
- out_ready  input  1  sink accepts out_data
- out_valid  output  1  out_data/out_row/out_col valid
- out_data  output  8  Float8 result pixel
- out_row  output  $clog2(OUT_H) (min 1)  row of current pixel
- out_col  output  $clog2(OUT_W) (min 1)  column of current pixel
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after last pixel transfer
- overflow  output  1  sticky saturation flag for current frame

## Operation
- Float8: s[7], e[6:3] bias 7, m[2:0]; value (-1)^s·2^(e-7)·(1+m/8) for e≥1; e=0 is zero (0x00 emitted). No inf/NaN.
- Multiply and add: compute exact result, truncate toward zero to Float8. Magnitude >0x7F value (480) saturates to 0x7F/0xFF and sets overflow. Magnitude <1·2^-6 flushes to 0x00, no flag.
- Per pixel (r,x): acc=0. For c, then kr, then kc, in ascending order: acc = acc + tensor(c,r+kr,x+kc)·filter(c,kr,kc). Then acc = acc + bias. This order is normative, because truncation makes the sum order-dependent.
- States:
  - IDLE: go to MAC on start. Clear overflow and pixel counters.
  - MAC: one term per cycle, K*K*CH cycles.
  - BIAS: one cycle.
  - EMIT: out_valid=1 until out_ready. On transfer, go to MAC for the next raster pixel, or to DONE after pixel (OUT_H-1,OUT_W-1).
  - DONE: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE. The inputs are not registered; changing them while busy is undefined.

## Timing
- Reset values: out_valid=0, out_data=0, out_row=0, out_col=0, busy=0, done=0, overflow=0; state IDLE; accumulator 0. A reset mid-frame aborts with no further output.
- start sampled at edge T: MAC cycles T+1..T+N (N=K*K*CH), BIAS at T+N+1, out_valid high from T+N+2.
- Pixel period without backpressure: N+2 cycles (MAC restarts the cycle after the transfer edge).
- Backpressure: out_valid, out_data, out_row and out_col hold stable while out_ready=0. out_ready while out_valid=0 has no effect.
- done is asserted the cycle after the final transfer. busy falls with the return to IDLE, the cycle after done. A new start is accepted from that cycle.
- overflow stays set until the next accepted start or reset. It updates in the cycle the saturating operation completes.

## Configuration
- CONV_ENGINE_RELU_EN defined: in BIAS, a negative result (s=1, nonzero) is replaced by 0x00 before out_data. Overflow is still flagged on pre-ReLU saturation.
- Undefined: the signed result is emitted unchanged.

## Test plan
- Defaults, tensor all 0x38 (1.0), filter all 0x38, bias 0x00 → 64 pixels, each 0x58 (16.0; truncation stalls the sum at 16), raster order (0,0)…(7,7), done pulse after the last transfer, overflow=0.
- Tensor all 0x7F, filter all 0x7F → every product saturates; out_data 0x7F, overflow=1 until the next start.
- Tensor 0x38, filter 0xB8 (-1.0), bias 0x00 → out_data 0xD8 without CONV_ENGINE_RELU_EN, 0x00 with it.
- out_ready held low 10 cycles at pixel (0,0) → out_valid=1, out_data/out_row/out_col constant; no counter advance; pixel (0,1) out_valid 27 cycles after the transfer.
- start at cycle 0 → first out_valid at cycle 27 (N=25). start pulsed at cycle 5 → ignored, output unchanged.
- rst_n low for one cycle during MAC of pixel (0,3) → next cycle all outputs 0 and state IDLE. A following start yields the full 64-pixel frame.
